pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central pipeline controller for the five-stage core. It turns the stall requests from ID, EX and MEM into the 6-bit `stall` vector used by every pipeline register, including ID/EX. It also sequences exception and branch-redirect flushes through a small FSM, so a flush is never lost and never cuts off an outstanding memory access. A watchdog flags pathological stall lengths.

## Interface
Parameters:
- `MAX_STALL`, 255: consecutive stalled cycles that set `stall_timeout`.
- `CNT_W`, 8: width of the watchdog counter; must satisfy 2^CNT_W > MAX_STALL.

Ports:
- `clk` in 1: single clock; every flop is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stallreq_from_id` in 1: ID needs a bubble (load-use).
- `stallreq_from_ex` in 1: EX is busy with a multi-cycle op.
- `stallreq_from_mem` in 1: data bus wait.
- `flush_req` in 1: one-cycle redirect/exception request.
- `flush_pc` in 32: redirect target, valid with `flush_req`.
- `stall` out 6: bit 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB; 1 = Stop.
- `flush` out 1: clear all pipeline registers this cycle.
- `new_pc` out 32: PC to load while `flush`=1.
- `stall_timeout` out 1: sticky watchdog flag.
- `stall_cycles` out 32: total stalled-cycle count (see Configuration).

## Operation
- States: RUN, PEND, FLUSH. Reset state is RUN.
- Stall encoding is combinational, highest-priority source first:
  - MEM request: `stall` = 6'b011111.
  - Otherwise EX request: 6'b001111.
  - Otherwise ID request: 6'b000111.
  - Otherwise: 6'b000000.
- RUN:
  - `stall` follows the encoding.
  - On an edge with `flush_req`=1, capture `flush_pc` into the pending PC register.
  - Next state is PEND if `stallreq_from_mem`=1, otherwise FLUSH.
- PEND:
  - `stall` follows the encoding.
  - Further `flush_req` pulses are ignored; the first captured target wins.
  - Move to FLUSH on the first edge where `stallreq_from_mem`=0.
- FLUSH (exactly one cycle):
  - `flush`=1, `new_pc` = captured PC, `stall`=6'b000000. All stall requests are masked.
  - A `flush_req` in this cycle is ignored.
  - Always returns to RUN.
- `new_pc` is 0 and `flush` is 0 in every state other than FLUSH.
- Watchdog:
  - The counter increments on each edge where `stall[0]`=1 and clears on any edge where it is 0. It saturates at MAX_STALL.
  - `stall_timeout` is set on the edge where the counter reaches MAX_STALL and is cleared only by `rst`.

## Timing
- Stall path: zero latency, combinational from the request inputs to `stall`, in RUN and PEND.
- Flush latency:
  - `flush_req` at edge N with no MEM stall gives `flush`=1 in cycle N+1.
  - If MEM is stalled, `flush` asserts in the cycle after the edge at which the MEM stall is seen deasserted.
- Reset values: state RUN, `stall`=0, `flush`=0, `new_pc`=0, `stall_timeout`=0, `stall_cycles`=0, watchdog counter 0, pending PC 0.
- Reset mid-operation: a pending or in-progress flush is discarded and the captured PC is lost.
- Simultaneous `flush_req` and stall requests in RUN: the stall is applied this cycle and the flush follows the rules above.
- Stall requests held through FLUSH are honoured again in the next RUN cycle.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `stall_cycles` is a 32-bit counter, incremented on each edge where `stall`≠0.
  - It wraps modulo 2^32 and resets to 0.
- Not defined: `stall_cycles` is tied to 0 and no counter flops are built.
- The watchdog is present in both builds.

## Structure
- Shared package (`defines.v`) holds:
  - `Stop`/`NoStop` and `RstEnable`.
  - The three stall encodings, named `STALL_ID`, `STALL_EX` and `STALL_MEM`.
  - The state codes `CTRL_RUN`, `CTRL_PEND` and `CTRL_FLUSH`.
- One sub-module, `stall_watchdog` (counter, saturation, sticky flag), parameterised by `MAX_STALL` and `CNT_W`. The FSM and encoder stay in `pipeline_ctrl`.

## Test plan
- Encoder priority:
  - `stallreq_from_id`=1 alone gives `stall`=6'b000111.
  - Adding EX gives 6'b001111.
  - Adding MEM gives 6'b011111.
  - Releasing all gives 0, all in the same cycle.
- Plain flush: `flush_req`=1 with `flush_pc`=32'h0000_0100 at edge N gives `flush`=1 and `new_pc`=32'h100 in cycle N+1, then `flush`=0 and `new_pc`=0.
- Deferred flush:
  - MEM stall held 3 cycles with `flush_req` on its first edge, plus a second `flush_req` (pc 32'h200) during PEND.
  - Single `flush` with `new_pc`=32'h100, one cycle after the MEM stall drops.
- Flush masking: `stallreq_from_ex`=1 throughout a FLUSH cycle gives `stall`=0 in FLUSH and 6'b001111 in the next cycle.
- Watchdog: with `MAX_STALL`=4, ID stall held 6 cycles sets `stall_timeout` after the 4th stalled edge. It stays 1 after the stall drops and clears only on `rst`.
- Reset in PEND clears the state to RUN; no `flush` is ever produced for the discarded request. With `PIPE_PERF_CNT_EN`, `stall_cycles` reads 0 after reset and then 5 after 5 stalled cycles.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared constants, stall encodings and controller state codes
package pipeline_ctrl_pkg;

    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam logic RstEnable = 1'b1;

    // Stall vector bit order: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
    localparam logic [5:0] STALL_ID  = 6'b000111;
    localparam logic [5:0] STALL_EX  = 6'b001111;
    localparam logic [5:0] STALL_MEM = 6'b011111;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_PEND  = 2'd1,
        CTRL_FLUSH = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/stall_watchdog.sv
// rtl/stall_watchdog.sv - consecutive-stall counter with saturation and sticky timeout flag
module stall_watchdog
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 255,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_pc_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Count consecutive PC-stalled edges, hold at the limit, latch the flag once the limit is hit
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (stall_pc_i != Stop) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((stall_pc_i == Stop) && (cnt_d == MAX_CNT)) begin
            timeout_d = 1'b1;
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall encoder, flush sequencing FSM, watchdog; PIPE_PERF_CNT_EN adds stall_cycles counter
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 255,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    ctrl_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [5:0]  stall_enc;

    // Priority encoder: the deepest requesting stage freezes everything upstream of it
    always_comb begin
        stall_enc = {6{NoStop}};
        if (stallreq_from_mem) begin
            stall_enc = STALL_MEM;
        end else if (stallreq_from_ex) begin
            stall_enc = STALL_EX;
        end else if (stallreq_from_id) begin
            stall_enc = STALL_ID;
        end
    end

    // Flush sequencing: capture the first target, wait out a MEM stall, then flush for one cycle
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stall   = stall_enc;
        flush   = 1'b0;
        new_pc  = 32'd0;
        case (state_q)
            CTRL_RUN: begin
                if (flush_req) begin
                    pc_d    = flush_pc;
                    state_d = stallreq_from_mem ? CTRL_PEND : CTRL_FLUSH;
                end
            end
            CTRL_PEND: begin
                if (!stallreq_from_mem) begin
                    state_d = CTRL_FLUSH;
                end
            end
            CTRL_FLUSH: begin
                flush   = 1'b1;
                new_pc  = pc_q;
                stall   = {6{NoStop}};
                state_d = CTRL_RUN;
            end
            default: begin
                state_d = CTRL_RUN;
            end
        endcase
    end

    // State and captured-target registers
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= CTRL_RUN;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    stall_watchdog #(
        .MAX_STALL (MAX_STALL),
        .CNT_W     (CNT_W)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .stall_pc_i (stall[0]),
        .timeout_o  (stall_timeout)
    );

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Free-running count of cycles with any stage stalled, wrapping naturally
    always_comb begin
        perf_d = perf_q;
        if (stall != {6{NoStop}}) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Performance counter register
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized self-checking bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

    localparam int MAX_STALL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_from_id, stallreq_from_ex, stallreq_from_mem;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: flags describing what the next cycles should look like
    bit          m_flush_now;
    bit          m_waiting;
    logic [31:0] m_pc;
    int          m_run;
    bit          m_to;
    logic [31:0] m_perf;

    pipeline_ctrl #(
        .MAX_STALL (MAX_STALL),
        .CNT_W     (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .flush_req         (flush_req),
        .flush_pc          (flush_pc),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_timeout     (stall_timeout),
        .stall_cycles      (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Number of frozen stages grows with the depth of the requester: ID 3, EX 4, MEM 5
    function automatic logic [5:0] model_stall(input bit id, input bit ex, input bit mem);
        int n;
        n = mem ? 5 : (ex ? 4 : (id ? 3 : 0));
        return 6'((1 << n) - 1);
    endfunction

    task automatic model_reset();
        m_flush_now = 0;
        m_waiting   = 0;
        m_pc        = 32'd0;
        m_run       = 0;
        m_to        = 0;
        m_perf      = 32'd0;
    endtask

    // One clock: drive at negedge, check before posedge, advance model across the edge
    task automatic cycle(input bit id, input bit ex, input bit mem, input bit fr,
                         input logic [31:0] pc, input bit r);
        logic [5:0] e_stall;
        stallreq_from_id  = id;
        stallreq_from_ex  = ex;
        stallreq_from_mem = mem;
        flush_req         = fr;
        flush_pc          = pc;
        rst               = r;
        #2;
        e_stall = m_flush_now ? 6'd0 : model_stall(id, ex, mem);
        check("stall",   {26'd0, stall}, {26'd0, e_stall});
        check("flush",   {31'd0, flush}, {31'd0, m_flush_now});
        check("new_pc",  new_pc, m_flush_now ? m_pc : 32'd0);
        check("timeout", {31'd0, stall_timeout}, {31'd0, m_to});
`ifdef PIPE_PERF_CNT_EN
        check("stall_cycles", stall_cycles, m_perf);
`else
        check("stall_cycles", stall_cycles, 32'd0);
`endif
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_run = e_stall[0] ? m_run + 1 : 0;
            if (m_run >= MAX_STALL) m_to = 1;
            if (e_stall != 6'd0) m_perf = m_perf + 32'd1;
            if (m_flush_now) begin
                m_flush_now = 0;
            end else if (m_waiting) begin
                if (!mem) begin
                    m_waiting   = 0;
                    m_flush_now = 1;
                end
            end else if (fr) begin
                m_pc = pc;
                if (mem) m_waiting = 1;
                else     m_flush_now = 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        stallreq_from_id  = 0;
        stallreq_from_ex  = 0;
        stallreq_from_mem = 0;
        flush_req         = 0;
        flush_pc          = 32'd0;
        rst               = 1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values
        cycle(0, 0, 0, 0, 32'd0, 1);
        cycle(0, 0, 0, 0, 32'd0, 0);

        // Encoder priority
        cycle(1, 0, 0, 0, 32'd0, 0);
        cycle(1, 1, 0, 0, 32'd0, 0);
        cycle(1, 1, 1, 0, 32'd0, 0);
        cycle(0, 0, 0, 0, 32'd0, 0);

        // Plain flush
        cycle(0, 0, 0, 1, 32'h0000_0100, 0);
        cycle(0, 0, 0, 0, 32'd0, 0);
        cycle(0, 0, 0, 0, 32'd0, 0);

        // Deferred flush with a losing second request in PEND
        cycle(0, 0, 1, 1, 32'h0000_0100, 0);
        cycle(0, 0, 1, 1, 32'h0000_0200, 0);
        cycle(0, 0, 1, 0, 32'd0, 0);
        cycle(0, 0, 0, 0, 32'd0, 0);
        cycle(0, 0, 0, 0, 32'd0, 0);
        cycle(0, 0, 0, 0, 32'd0, 0);

        // Flush masking with EX held through FLUSH, plus a flush_req in FLUSH
        cycle(0, 1, 0, 1, 32'h0000_0300, 0);
        cycle(0, 1, 0, 1, 32'h0000_0400, 0);
        cycle(0, 1, 0, 0, 32'd0, 0);
        cycle(0, 0, 0, 0, 32'd0, 0);

        // Watchdog: long ID stall, flag sticks until reset
        cycle(0, 0, 0, 0, 32'd0, 1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 32'd0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'd0, 0);
        cycle(0, 0, 0, 0, 32'd0, 1);
        cycle(0, 0, 0, 0, 32'd0, 0);

        // Reset while PEND discards the request; then 5 stalled cycles for the perf counter
        cycle(0, 0, 1, 1, 32'h0000_0500, 0);
        cycle(0, 0, 1, 0, 32'd0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'd0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 32'd0, 0);
        cycle(0, 0, 0, 0, 32'd0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 20,
                  $urandom,
                  $urandom_range(0, 99) < 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
